// File: rtl/aeolus_sequencer_if.sv
// Instruction handshake bundle between the instruction source (switch bank or
// program store) and the Aeolus sequencer.
//   instr       : 8-bit instruction, [7:4] opcode, [3:0] operand flags
//   instr_valid : source has an instruction; instr held stable while high
//   instr_ready : sequencer can accept; transfer on rising edge with valid
// master = instruction source, slave = sequencer.
interface aeolus_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/aeolus_sequencer.sv
// Aeolus sequencer: control FSM for the 4-bit Aeolus datapath.
// Accepts 8-bit instructions over a valid/ready handshake, decodes them and
// drives single-cycle load enables / operation selects for the datapath.
// Every output is a flop updated from the state transition (Moore), so there
// is no combinational path from instr to any strobe.
//
// Ports:
//   sysCLK      system clock (post divider)
//   reset       asynchronous active-low reset
//   ibus        instruction handshake (slave side): instr/instr_valid/instr_ready
//   overflow    AU overflow, sampled only at the end of WB
//   resume      leaves HALT; ignored elsewhere
//   LDA/LDB     RegA/RegB load enables, srcSel selects their source (1=ACCout)
//   CLR         synchronous ACC clear
//   EnableACC   ACC load enable (WB cycle of ALU ops)
//   EnableO     output register load enable
//   add/sub/lshift/rshift  one-hot AU select, all zero when idle
//   busy        high in DECODE/EXEC/WB
//   halted      high in HALT
//   ovf_flag    sticky overflow flag, cleared only by reset
//   illegal     sticky illegal-opcode flag, cleared only by reset
//   retired     completed-instruction counter, wraps
//
// Build option: define AEOLUS_SEQ_OVF_TRAP_EN to stop in HALT after an ALU
// instruction whose WB cycle saw overflow=1 (the result is still written).
module aeolus_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             sysCLK,
  input  logic             reset,
  aeolus_sequencer_if.slave ibus,
  input  logic             overflow,
  input  logic             resume,
  output logic             LDA,
  output logic             LDB,
  output logic             CLR,
  output logic             EnableACC,
  output logic             EnableO,
  output logic             add,
  output logic             sub,
  output logic             lshift,
  output logic             rshift,
  output logic             srcSel,
  output logic             busy,
  output logic             halted,
  output logic             ovf_flag,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDB  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_LSH  = 4'h5,
    OP_RSH  = 4'h6,
    OP_CLRA = 4'h7,
    OP_OUT  = 4'h8,
    OP_HALT = 4'h9
  } opcode_t;

  state_t     state;
  logic [7:0] ir;
  logic       ready;

  logic [3:0] op;
  logic       alu_op;

  assign op     = ir[7:4];
  assign alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_LSH) || (op == OP_RSH);

  // Operand flags [3:1] are reserved; only IR[0] (load source) is decoded.
  wire unused_ir = ^ir[3:1];

  assign ibus.instr_ready = ready;

  always_ff @(posedge sysCLK or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      ready     <= 1'b1;
      LDA       <= 1'b0;
      LDB       <= 1'b0;
      CLR       <= 1'b0;
      EnableACC <= 1'b0;
      EnableO   <= 1'b0;
      add       <= 1'b0;
      sub       <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      srcSel    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      ovf_flag  <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      // Strobes live for exactly one cycle; the state that wants one
      // re-asserts it below, so they can never overlap across instructions.
      LDA       <= 1'b0;
      LDB       <= 1'b0;
      CLR       <= 1'b0;
      EnableACC <= 1'b0;
      EnableO   <= 1'b0;
      add       <= 1'b0;
      sub       <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      srcSel    <= 1'b0;

      case (state)
        S_FETCH: begin
          if (ibus.instr_valid && ready) begin
            ir    <= ibus.instr;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_DECODE;
          end
        end

        // Strobes for EXEC are computed here so they come straight from flops.
        S_DECODE: begin
          state <= S_EXEC;
          case (op)
            OP_NOP:  ;
            OP_LDA:  begin LDA <= 1'b1; srcSel <= ir[0]; end
            OP_LDB:  begin LDB <= 1'b1; srcSel <= ir[0]; end
            OP_ADD:  add     <= 1'b1;
            OP_SUB:  sub     <= 1'b1;
            OP_LSH:  lshift  <= 1'b1;
            OP_RSH:  rshift  <= 1'b1;
            OP_CLRA: CLR     <= 1'b1;
            OP_OUT:  EnableO <= 1'b1;
            OP_HALT: ;
            default: illegal <= 1'b1;   // 0xA-0xF execute as NOP
          endcase
        end

        S_EXEC: begin
          if (alu_op) begin
            // AU result is registered, so ACC captures it one cycle later.
            EnableACC <= 1'b1;
            state     <= S_WB;
          end else begin
            retired <= retired + CNT_W'(1);
            busy    <= 1'b0;
            if (op == OP_HALT) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              ready <= 1'b1;
              state <= S_FETCH;
            end
          end
        end

        S_WB: begin
          retired <= retired + CNT_W'(1);
          busy    <= 1'b0;
          if (overflow) ovf_flag <= 1'b1;
`ifdef AEOLUS_SEQ_OVF_TRAP_EN
          if (overflow) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            ready <= 1'b1;
            state <= S_FETCH;
          end
`else
          ready <= 1'b1;
          state <= S_FETCH;
`endif
        end

        S_HALT: begin
          if (resume) begin
            halted <= 1'b0;
            ready  <= 1'b1;
            state  <= S_FETCH;
          end
        end

        default: begin
          busy   <= 1'b0;
          halted <= 1'b0;
          ready  <= 1'b1;
          state  <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aeolus_sequencer.sv
// Self-checking bench for aeolus_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_aeolus_sequencer;
  localparam int CNT_W = 8;

  // Strobe vector bit positions
  localparam int B_LDA = 9, B_LDB = 8, B_CLR = 7, B_EACC = 6, B_EO = 5;
  localparam int B_ADD = 4, B_SUB = 3, B_LSH = 2, B_RSH = 1, B_SRC = 0;

  logic sysCLK = 1'b0;
  logic reset;
  logic overflow, resume;
  logic LDA, LDB, CLR, EnableACC, EnableO, add, sub, lshift, rshift, srcSel;
  logic busy, halted, ovf_flag, illegal;
  logic [CNT_W-1:0] retired;

  aeolus_sequencer_if bus ();

  aeolus_sequencer #(.CNT_W(CNT_W)) dut (
    .sysCLK(sysCLK), .reset(reset), .ibus(bus.slave),
    .overflow(overflow), .resume(resume),
    .LDA(LDA), .LDB(LDB), .CLR(CLR), .EnableACC(EnableACC), .EnableO(EnableO),
    .add(add), .sub(sub), .lshift(lshift), .rshift(rshift), .srcSel(srcSel),
    .busy(busy), .halted(halted), .ovf_flag(ovf_flag), .illegal(illegal),
    .retired(retired)
  );

  always #5 sysCLK = ~sysCLK;

  wire [9:0] strb = {LDA, LDB, CLR, EnableACC, EnableO, add, sub, lshift, rshift, srcSel};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (instruction granularity)
  int retired_m = 0;
  bit ovf_m = 0, ill_m = 0, halted_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The EXEC-cycle strobe pattern each opcode calls for.
  function automatic logic [9:0] exp_exec(input logic [7:0] ins);
    logic [9:0] v;
    v = '0;
    case (ins[7:4])
      4'h1: begin v[B_LDA] = 1'b1; v[B_SRC] = ins[0]; end
      4'h2: begin v[B_LDB] = 1'b1; v[B_SRC] = ins[0]; end
      4'h3: v[B_ADD] = 1'b1;
      4'h4: v[B_SUB] = 1'b1;
      4'h5: v[B_LSH] = 1'b1;
      4'h6: v[B_RSH] = 1'b1;
      4'h7: v[B_CLR] = 1'b1;
      4'h8: v[B_EO]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_strb"}, strb, 0);
    chk({tag, "_rdy"}, bus.instr_ready, !halted_m);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halt"}, halted, halted_m);
    chk({tag, "_ret"}, retired, retired_m);
    chk({tag, "_ovf"}, ovf_flag, ovf_m);
    chk({tag, "_ill"}, illegal, ill_m);
  endtask

  // Issue one instruction from FETCH; called and returns at a negedge.
  task automatic do_instr(input logic [7:0] ins, input logic ovf_in);
    logic [3:0] op;
    bit alu;
    op  = ins[7:4];
    alu = (op >= 4'h3) && (op <= 4'h6);
    chk("pre_rdy", bus.instr_ready, 1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge sysCLK); #1;
    bus.instr_valid = 1'b0;
    bus.instr = 8'($urandom);
    @(negedge sysCLK);                       // DECODE
    if (!alu) overflow = 1'($urandom);       // must be ignored outside WB
    chk("dec_strb", strb, 0);
    chk("dec_busy", busy, 1);
    chk("dec_rdy", bus.instr_ready, 0);
    @(negedge sysCLK);                       // EXEC
    chk("exec_strb", strb, exp_exec(ins));
    chk("exec_busy", busy, 1);
    chk("exec_rdy", bus.instr_ready, 0);
    if (op >= 4'hA) ill_m = 1;
    if (alu) begin
      overflow = ovf_in;
      @(negedge sysCLK);                     // WB
      chk("wb_strb", strb, 10'b1 << B_EACC);
      chk("wb_busy", busy, 1);
      chk("wb_rdy", bus.instr_ready, 0);
      if (ovf_in) begin
        ovf_m = 1;
`ifdef AEOLUS_SEQ_OVF_TRAP_EN
        halted_m = 1;
`endif
      end
    end else if (op == 4'h9) begin
      halted_m = 1;
    end
    retired_m = (retired_m + 1) % (1 << CNT_W);
    @(negedge sysCLK);
    overflow = 1'b0;
    chk_idle("post");
  endtask

  // Sit in HALT with valid asserted, then resume.
  task automatic do_resume(input int hold);
    bus.instr = 8'($urandom);
    bus.instr_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge sysCLK);
      chk("halt_rdy", bus.instr_ready, 0);
      chk("halt_hlt", halted, 1);
      chk("halt_strb", strb, 0);
      chk("halt_busy", busy, 0);
    end
    resume = 1'b1;
    @(posedge sysCLK); #1;
    resume = 1'b0;
    bus.instr_valid = 1'b0;
    halted_m = 0;
    @(negedge sysCLK);
    chk_idle("resumed");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    retired_m = 0; ovf_m = 0; ill_m = 0; halted_m = 0;
    chk("rst_strb", strb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halt", halted, 0);
    chk("rst_ret", retired, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_ill", illegal, 0);
    repeat (2) begin
      @(negedge sysCLK);
      chk("rst_hold_strb", strb, 0);
    end
    reset = 1'b1;
    @(negedge sysCLK);
    chk_idle("after_rst");
  endtask

  initial begin
    logic [7:0] ins;
    reset = 1'b0;
    overflow = 1'b0;
    resume = 1'b0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    @(negedge sysCLK);
    do_reset();

    // Basic program
    do_instr(8'h10, 1'b0);
    do_instr(8'h20, 1'b0);
    do_instr(8'h30, 1'b0);
    do_instr(8'h80, 1'b0);
    chk("prog_ret", retired, 4);

    // Idle in FETCH
    repeat (5) begin
      @(negedge sysCLK);
      chk_idle("idle");
    end

    // resume outside HALT is ignored
    resume = 1'b1;
    @(negedge sysCLK);
    resume = 1'b0;
    @(negedge sysCLK);
    chk_idle("stray_resume");

    // Illegal opcode then a normal one, srcSel=1 load
    do_instr(8'hC0, 1'b0);
    chk("ill_set", illegal, 1);
    do_instr(8'h11, 1'b0);
    do_instr(8'h21, 1'b0);

    // HALT and resume
    do_instr(8'h90, 1'b0);
    do_resume(4);

    // ALU op with overflow in WB
    do_instr(8'h30, 1'b1);
    chk("ovf_set", ovf_flag, 1);
    if (halted_m) do_resume(2);
    do_instr(8'h70, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      ins = 8'($urandom);
      do_instr(ins, 1'($urandom_range(0, 3) == 0));
      if (halted_m) do_resume($urandom_range(1, 3));
    end

    // Reset during EXEC of SUB
    bus.instr = 8'h40;
    bus.instr_valid = 1'b1;
    @(posedge sysCLK); #1;
    bus.instr_valid = 1'b0;
    @(negedge sysCLK);
    @(negedge sysCLK);
    chk("sub_exec", strb, 10'b1 << B_SUB);
    do_reset();

    // Reset and resume together in HALT: reset wins
    do_instr(8'h90, 1'b0);
    resume = 1'b1;
    do_reset();
    resume = 1'b0;

    // Counter wrap
    for (int n = 0; n < 256; n++) do_instr(8'h00, 1'b0);
    chk("wrap_ret", retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
